// File: rtl/reg_bank_pkg.sv
// Shared select helpers for the register bank and the control unit.
package reg_bank_pkg;

    localparam int MAX_RPORTS = 4;
    localparam int MAX_SIZE   = 32;

    typedef logic [MAX_SIZE-1:0] sel_t;

    function automatic logic onehot_ok(input sel_t vec);
        return (vec != '0) && ((vec & (vec - sel_t'(1))) == '0);
    endfunction

    function automatic sel_t idx_to_onehot(input int unsigned idx);
        return sel_t'(1) << idx;
    endfunction

endpackage

// File: rtl/onehot_rd_port.sv
// One combinational read port: one-hot mux, write-through bypass and busy qualification.
module onehot_rd_port
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SIZE  = 8
) (
    input  logic [SIZE-1:0][WIDTH-1:0] regs_i,
    input  logic [SIZE-1:0]            busy_i,
    input  logic [SIZE-1:0]            sel_i,
    input  logic [SIZE-1:0]            wsel_i,
    input  logic                       wen_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       rvalid_o,
    output logic                       multi_o
);

    logic [WIDTH-1:0] mux;
    logic             sel_oh;
    logic             hit;

    always_comb begin
        mux = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (sel_i[i]) mux = mux | regs_i[i];
        end
    end

    assign sel_oh = onehot_ok(sel_t'(sel_i));
    // wsel_i arrives already masked, so writes to a hard-wired zero register never bypass
    assign hit      = wen_i && sel_oh && (sel_i == wsel_i);
    assign data_o   = !sel_oh ? '0 : (hit ? wdata_i : mux);
    assign rvalid_o = sel_oh && (((busy_i & sel_i) == '0) || hit);
    assign multi_o  = (sel_i != '0) && !sel_oh;

endmodule

// File: rtl/reg_bank_mp.sv
// Multi-port one-hot register bank with write-through bypass, busy scoreboard,
// optional zero register and sticky select-error flag.
module reg_bank_mp
    import reg_bank_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SIZE     = 8,
    parameter int RPORTS   = 2,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         in,
    input  logic [SIZE-1:0]          selectW,
    input  logic [SIZE-1:0]          reserve,
    input  logic [RPORTS*SIZE-1:0]   selectR,
    output logic [RPORTS*WIDTH-1:0]  out,
    output logic [RPORTS-1:0]        rvalid,
    output logic [SIZE-1:0]          busy,
    output logic                     sel_err
);

    localparam logic [SIZE-1:0] KEEP_MASK = (ZERO_REG != 0) ? ~SIZE'(1) : '1;

    logic [SIZE-1:0][WIDTH-1:0] regs_q, regs_d;
    logic [SIZE-1:0]            busy_q, busy_d;
    logic                       sel_err_q, sel_err_d;

    logic            wr_oh, wr_multi, res_oh, res_multi;
    logic [SIZE-1:0] wr_sel, res_sel;
    logic [RPORTS-1:0] rd_multi;

    assign wr_oh     = onehot_ok(sel_t'(selectW));
    assign wr_multi  = (selectW != '0) && !wr_oh;
    assign wr_sel    = (enable && wr_oh) ? (selectW & KEEP_MASK) : '0;
    assign res_oh    = onehot_ok(sel_t'(reserve));
    assign res_multi = (reserve != '0) && !res_oh;
    assign res_sel   = res_oh ? (reserve & KEEP_MASK) : '0;

    for (genvar p = 0; p < RPORTS; p++) begin : g_rd
        onehot_rd_port #(
            .WIDTH (WIDTH),
            .SIZE  (SIZE)
        ) u_rd (
            .regs_i   (regs_q),
            .busy_i   (busy_q),
            .sel_i    (selectR[p*SIZE +: SIZE]),
            .wsel_i   (wr_sel),
            .wen_i    (|wr_sel),
            .wdata_i  (in),
            .data_o   (out[p*WIDTH +: WIDTH]),
            .rvalid_o (rvalid[p]),
            .multi_o  (rd_multi[p])
        );
    end

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < SIZE; i++) begin
            if (wr_sel[i]) regs_d[i] = in;
        end
        // reserve is OR-ed after the writeback clear so it wins on the same register
        busy_d    = (busy_q & ~wr_sel) | res_sel;
        sel_err_d = sel_err_q | wr_multi | res_multi | (|rd_multi);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q    <= '0;
            busy_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            busy_q    <= busy_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign busy    = busy_q;
    assign sel_err = sel_err_q;

endmodule
